// File: rtl/counter_pkg.sv
// Shared helpers for the toggle-cell modulo counters: width sizing and the
// terminal (MODULUS-1) value.
package counter_pkg;

  function automatic int clog2(input longint value);
    longint rem;
    int     bits;
    rem  = value - 1;
    bits = 0;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

  // Terminal count of a modulo-MODULUS counter, masked to WIDTH bits.
  function automatic longint term_val(input int width, input int modulus);
    longint mask;
    mask = (longint'(1) <<< width) - 1;
    return longint'(modulus - 1) & mask;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit toggle cell with synchronous reset and load overrides.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= 1'b0;
    else if (ld) q <= d;
    else         q <= q ^ t;
  end

endmodule

// File: rtl/tff_updown_counter.sv
// Up/down modulo counter built from WIDTH toggle cells, with parallel load,
// cascade carry (tc) and registered wrap / load_err pulses.
module tff_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(term_val(WIDTH, MODULUS));

  if (WIDTH < 1 || MODULUS < 2 || clog2(longint'(MODULUS)) > WIDTH) begin : g_bad_params
    $error("tff_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end

  logic             at_term;
  logic             at_zero;
  logic             hit_end;
  logic             din_ok;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] load_val;

  assign at_term = (q == TERM);
  assign at_zero = (q == '0);
  assign hit_end = up ? at_term : at_zero;
  // Widen by one bit so MODULUS = 2**WIDTH still compares correctly.
  assign din_ok  = ({1'b0, din} < (WIDTH+1)'(MODULUS));

  assign tc = en & ~load & ~reset & hit_end;

  always_comb begin
    cnt_next = q;
    if (en) begin
      if (up) cnt_next = at_term ? '0 : q + WIDTH'(1);
      else    cnt_next = at_zero ? TERM : q - WIDTH'(1);
    end
  end

  assign toggle   = q ^ cnt_next;
  assign load_val = din_ok ? din : TERM;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .t    (toggle[i]),
      .ld   (load),
      .d    (load_val[i]),
      .q    (q[i])
    );
  end

  // Pulses line up with the q update that caused them; load masks wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= en & ~load & hit_end;
      load_err <= load & ~din_ok;
    end
  end

endmodule
